// File: rtl/zero_count_byte_gen_pkg.sv
// Shared types, constants and the zero-pattern helper for the zero-count byte generator.
// The pattern function is the single definition of which bit positions carry zeros.
package zcb_pkg;

   localparam int BYTE_W = 8;
   localparam int CNT_W  = 4;
   localparam int IDX_W  = 3;
   localparam logic [CNT_W-1:0] MAX_ZEROS = 4'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } zcb_state_e;

   // Clamp a requested count to the byte width.
   function automatic logic [CNT_W-1:0] zcb_sat(input logic [CNT_W-1:0] zcnt);
      if (zcnt > MAX_ZEROS) begin
         zcb_sat = MAX_ZEROS;
      end else begin
         zcb_sat = zcnt;
      end
   endfunction

   // Pattern bit at position idx; for n=0 the MSB bound is 8, which no 3-bit index reaches.
   function automatic logic zcb_bit_at(input logic [CNT_W-1:0] n,
                                       input logic             mode,
                                       input logic [IDX_W-1:0] idx);
      logic [CNT_W-1:0] idx_w;
      logic [CNT_W-1:0] msb_bound;
      idx_w     = {1'b0, idx};
      msb_bound = MAX_ZEROS - n;
      if (mode == 1'b0) begin
         zcb_bit_at = (idx_w < n) ? 1'b0 : 1'b1;
      end else begin
         zcb_bit_at = (idx_w >= msb_bound) ? 1'b0 : 1'b1;
      end
   endfunction

endpackage

// File: rtl/zero_count_byte_gen.sv
// Serial byte generator: emits a byte with exactly the requested number of zeros, LSB first,
// then presents the assembled byte in parallel with a one-cycle valid pulse.
module zero_count_byte_gen
   import zcb_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CNT_W-1:0]  zcnt,
   input  logic              mode,
   output logic              bit_out,
   output logic              bit_valid,
   output logic [IDX_W-1:0]  bit_idx,
   output logic [BYTE_W-1:0] byte_out,
   output logic              byte_valid,
   output logic              sat_err
);

   zcb_state_e        state_r;
   zcb_state_e        state_next_s;
   logic [CNT_W-1:0]  n_r;
   logic [CNT_W-1:0]  n_next_s;
   logic              mode_r;
   logic              mode_next_s;
   logic              sat_r;
   logic              sat_next_s;
   logic [BYTE_W-1:0] asm_r;
   logic [BYTE_W-1:0] asm_next_s;
   logic              bit_out_next_s;
   logic              bit_valid_next_s;
   logic [IDX_W-1:0]  bit_idx_next_s;
   logic [BYTE_W-1:0] byte_out_next_s;
   logic              byte_valid_next_s;
   logic              sat_err_next_s;
   logic              handshake_s;
   logic [CNT_W-1:0]  n_in_s;

   assign in_ready    = (state_r == IDLE);
   assign handshake_s = in_valid & in_ready;
   assign n_in_s      = zcb_sat(zcnt);

   // Next-state and datapath decode; bit_idx doubles as the internal shift index.
   always_comb begin
      state_next_s      = state_r;
      n_next_s          = n_r;
      mode_next_s       = mode_r;
      sat_next_s        = sat_r;
      asm_next_s        = asm_r;
      bit_out_next_s    = bit_out;
      bit_valid_next_s  = 1'b0;
      bit_idx_next_s    = bit_idx;
      byte_out_next_s   = byte_out;
      byte_valid_next_s = 1'b0;
      sat_err_next_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (handshake_s) begin
               state_next_s     = SHIFT;
               n_next_s         = n_in_s;
               mode_next_s      = mode;
               sat_next_s       = (zcnt > MAX_ZEROS);
               asm_next_s       = 8'hFF;
               bit_idx_next_s   = 3'd0;
               bit_out_next_s   = zcb_bit_at(n_in_s, mode, 3'd0);
               bit_valid_next_s = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         SHIFT: begin
            asm_next_s[bit_idx] = zcb_bit_at(n_r, mode_r, bit_idx);
            if (bit_idx == 3'd7) begin
               // Final bit lands in the same edge that publishes the byte.
               state_next_s      = DONE;
               byte_out_next_s   = asm_next_s;
               byte_valid_next_s = 1'b1;
               sat_err_next_s    = sat_r;
            end else begin
               bit_idx_next_s   = bit_idx + 3'd1;
               bit_out_next_s   = zcb_bit_at(n_r, mode_r, bit_idx + 3'd1);
               bit_valid_next_s = 1'b1;
            end
         end
         DONE: begin
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         n_r        <= 4'd0;
         mode_r     <= 1'b0;
         sat_r      <= 1'b0;
         asm_r      <= 8'hFF;
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         bit_idx    <= 3'd0;
         byte_out   <= 8'h00;
         byte_valid <= 1'b0;
         sat_err    <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         n_r        <= n_next_s;
         mode_r     <= mode_next_s;
         sat_r      <= sat_next_s;
         asm_r      <= asm_next_s;
         bit_out    <= bit_out_next_s;
         bit_valid  <= bit_valid_next_s;
         bit_idx    <= bit_idx_next_s;
         byte_out   <= byte_out_next_s;
         byte_valid <= byte_valid_next_s;
         sat_err    <= sat_err_next_s;
      end
   end

endmodule

// File: tb/tb_zero_count_byte_gen.sv
// Scoreboard bench for zero_count_byte_gen: expected bits/bytes are queued at request time
// and popped by a negedge monitor that also runs a serial zero counter on bit_out.
module tb_zero_count_byte_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] zcnt = 4'd0;
   logic       mode = 1'b0;
   logic       bit_out;
   logic       bit_valid;
   logic [2:0] bit_idx;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       sat_err;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int zc = 0;
   int last_acc = 0;
   int w = 0;
   logic [7:0] last_byte = 8'h00;

   logic [3:0] bit_q[$];
   logic [8:0] byte_q[$];
   int         zc_q[$];

   zero_count_byte_gen dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .zcnt(zcnt), .mode(mode), .bit_out(bit_out), .bit_valid(bit_valid),
      .bit_idx(bit_idx), .byte_out(byte_out), .byte_valid(byte_valid), .sat_err(sat_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Queue the expected stream for one request.
   task automatic push_exp(input int z, input logic m);
      int n;
      logic [7:0] ones;
      logic [7:0] b;
      n    = (z > 8) ? 8 : z;
      ones = 8'hFF;
      b    = m ? (ones >> n) : (ones << n);
      for (int i = 0; i < 8; i++) bit_q.push_back({i[2:0], b[i]});
      byte_q.push_back({(z > 8) ? 1'b1 : 1'b0, b});
      zc_q.push_back(n);
      last_byte = b;
   endtask

   task automatic wait_idle();
      int t;
      logic done;
      done = 1'b0;
      t = 0;
      while (!done && t < 40) begin
         @(posedge clk); #1;
         t++;
         if (in_ready && byte_q.size() == 0 && bit_q.size() == 0) done = 1'b1;
      end
      check("idle_timeout", done, 1);
      check("byte_hold", byte_out, last_byte);
   endtask

   task automatic do_req(input int z, input logic m);
      in_valid = 1'b1;
      zcnt = z[3:0];
      mode = m;
      push_exp(z, m);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("first_bit_valid", bit_valid, 1);
      zcnt = 4'($urandom_range(0, 15));
      mode = ~m;
   endtask

   // Monitor: compare serial bits, loopback zero count, and completed bytes.
   always @(negedge clk) begin
      logic [3:0] eb;
      logic [8:0] ey;
      if (!rst_n) begin
         zc = 0;
      end else begin
         if (bit_valid) begin
            check("ready_low_in_shift", in_ready, 0);
            if (bit_q.size() == 0) begin
               check("spurious_bit", 1, 0);
            end else begin
               eb = bit_q.pop_front();
               check("bit_idx", bit_idx, eb[3:1]);
               check("bit_out", bit_out, eb[0]);
               if (bit_out == 1'b0) zc++;
               if (bit_idx == 3'd7) begin
                  if (zc_q.size() == 0) check("zc_queue_empty", 1, 0);
                  else check("loopback_zero_count", zc, zc_q.pop_front());
                  zc = 0;
               end
            end
         end
         if (byte_valid) begin
            check("bit_valid_low_in_done", bit_valid, 0);
            if (byte_q.size() == 0) begin
               check("spurious_byte", 1, 0);
            end else begin
               ey = byte_q.pop_front();
               check("byte_out", byte_out, ey[7:0]);
               check("sat_err", sat_err, ey[8]);
            end
         end else begin
            check("sat_err_idle", sat_err, 0);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_byte_out", byte_out, 8'h00);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_sat_err", sat_err, 0);
      check("rst_bit_out", bit_out, 0);
      check("rst_bit_idx", bit_idx, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_req(3, 1'b0);  wait_idle();
      check("z3_m0_byte", byte_out, 8'hF8);
      do_req(3, 1'b1);  wait_idle();
      check("z3_m1_byte", byte_out, 8'h1F);
      do_req(0, 1'b0);  wait_idle();
      check("z0_byte", byte_out, 8'hFF);
      do_req(8, 1'b1);  wait_idle();
      check("z8_byte", byte_out, 8'h00);
      do_req(12, 1'b0); wait_idle();
      do_req(15, 1'b1); wait_idle();
      do_req(1, 1'b1);  wait_idle();
      check("z1_m1_byte", byte_out, 8'h7F);

      // Abort at bit_idx 4.
      do_req(5, 1'b0);
      w = 0;
      while (!(bit_valid && bit_idx == 3'd4) && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("abort_reached_idx4", bit_idx, 4);
      rst_n = 1'b0;
      bit_q.delete();
      byte_q.delete();
      zc_q.delete();
      #1;
      check("abort_byte_out", byte_out, 8'h00);
      check("abort_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      check("abort_no_byte_valid", byte_valid, 0);
      check("abort_no_bit_valid", bit_valid, 0);
      rst_n = 1'b1;
      last_byte = 8'h00;
      do_req(6, 1'b1);  wait_idle();
      check("post_abort_byte", byte_out, 8'h03);

      // Back-to-back sweep with in_valid held high.
      in_valid = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         w = 0;
         while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         check("b2b_ready", in_ready, 1);
         zcnt = k[3:0];
         mode = k[0];
         push_exp(k, k[0]);
         @(posedge clk); #1;
         if (k > 0) check("b2b_spacing", cyc - last_acc, 10);
         last_acc = cyc;
         check("b2b_first_bit", bit_valid, 1);
         zcnt = 4'($urandom_range(0, 15));
         mode = ~mode;
      end
      in_valid = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
